// File: rtl/i_cache_pkg.sv
// rtl/i_cache_pkg.sv - shared encodings and address field positions for i_cache
package i_cache_pkg;

  localparam int ADDR_W    = 32;
  localparam int WORD_W    = 32;
  localparam int BLOCK_W   = 128;
  localparam int OFFSET_W  = 4;
  localparam int WORD_LSB  = 2;
  localparam int WORD_SEL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_READ = 2'd1,
    ST_UPDATE   = 2'd2
  } state_t;

endpackage

// File: rtl/i_cache_ctrl.sv
// rtl/i_cache_ctrl.sv - miss-handling FSM and miss address register for i_cache
module i_cache_ctrl #(
  parameter int MEM_ADDR_W = 28
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ_EN,
  input  logic                  hit,
  input  logic [MEM_ADDR_W-1:0] req_addr,
  input  logic                  MEM_BUSYWAIT,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
  output logic                  refill_en,
  output logic [MEM_ADDR_W-1:0] miss_addr
);
  import i_cache_pkg::*;

  state_t state;
  state_t state_nxt;

  // miss_addr is captured only on the detecting edge so the CPU may move
  // ADDRESS freely while the refill is in flight
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      miss_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && READ_EN && !hit) begin
        miss_addr <= req_addr;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (READ_EN && !hit) state_nxt = ST_MEM_READ;
      ST_MEM_READ: if (!MEM_BUSYWAIT)   state_nxt = ST_UPDATE;
      ST_UPDATE:                        state_nxt = ST_IDLE;
      default:                          state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    BUSYWAIT    = 1'b0;
    MEM_READ    = 1'b0;
    MEM_ADDRESS = '0;
    refill_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        BUSYWAIT = READ_EN & ~hit;
      end
      ST_MEM_READ: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = miss_addr;
      end
      ST_UPDATE: begin
        BUSYWAIT  = 1'b1;
        refill_en = 1'b1;
      end
      default: begin
        BUSYWAIT = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/i_cache.sv
// rtl/i_cache.sv - direct-mapped instruction cache with single-block refill from i_mem
module i_cache #(
  parameter int INDEX_W    = 3,
  parameter int BLOCK_W    = 128,
  parameter int MEM_ADDR_W = 28
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ_EN,
  input  logic [31:0]           ADDRESS,
  output logic [31:0]           INSTRUCTION,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic [MEM_ADDR_W-1:0] MEM_ADDRESS,
  input  logic                  MEM_BUSYWAIT,
  input  logic [BLOCK_W-1:0]    MEM_READDATA
);
  import i_cache_pkg::*;

  localparam int TAG_W = ADDR_W - OFFSET_W - INDEX_W;
  localparam int SETS  = 1 << INDEX_W;

  logic [SETS-1:0]    valid;
  logic [TAG_W-1:0]   tag_array  [SETS];
  logic [BLOCK_W-1:0] data_array [SETS];

  logic [INDEX_W-1:0]    index;
  logic [TAG_W-1:0]      tag;
  logic [WORD_SEL_W-1:0] word_sel;
  logic                  hit;
  logic                  refill_en;
  logic [MEM_ADDR_W-1:0] miss_addr;
  logic [INDEX_W-1:0]    refill_index;
  logic [TAG_W-1:0]      refill_tag;
  logic                  unused_byte_offset;

  assign index    = ADDRESS[OFFSET_W +: INDEX_W];
  assign tag      = ADDRESS[OFFSET_W + INDEX_W +: TAG_W];
  assign word_sel = ADDRESS[WORD_LSB +: WORD_SEL_W];
  assign unused_byte_offset = ^ADDRESS[WORD_LSB-1:0];

  assign hit = READ_EN & valid[index] & (tag_array[index] == tag);

  always_comb begin
    INSTRUCTION = '0;
    if (hit) begin
      INSTRUCTION = data_array[index][word_sel*WORD_W +: WORD_W];
    end
  end

  assign refill_index = miss_addr[INDEX_W-1:0];
  assign refill_tag   = miss_addr[MEM_ADDR_W-1:INDEX_W];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid <= '0;
    end else if (refill_en) begin
      valid[refill_index] <= 1'b1;
    end
  end

  // read-only cache: a conflicting block is simply overwritten
  always_ff @(posedge CLK) begin
    if (refill_en) begin
      data_array[refill_index] <= MEM_READDATA;
      tag_array[refill_index]  <= refill_tag;
    end
  end

  i_cache_ctrl #(
    .MEM_ADDR_W (MEM_ADDR_W)
  ) u_ctrl (
    .CLK          (CLK),
    .RESET        (RESET),
    .READ_EN      (READ_EN),
    .hit          (hit),
    .req_addr     (ADDRESS[ADDR_W-1:OFFSET_W]),
    .MEM_BUSYWAIT (MEM_BUSYWAIT),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .refill_en    (refill_en),
    .miss_addr    (miss_addr)
  );

endmodule
